// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   RESET_PC : PC value after reset (matches the PC register's reset value)
//   INST_NOP : canonical NOP (addi x0, x0, 0), driven on inst_data while idle
//   BOOT/RUN/HALT : fetch FSM state encodings (HALT only reachable with
//                   IF_MISALIGN_TRAP_EN defined)
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t BOOT = 2'd0;
    localparam fetch_state_t RUN  = 2'd1;
    localparam fetch_state_t HALT = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO, DEPTH entries of WIDTH bits, optional empty bypass.
// With BYPASS=1 a push into an empty FIFO is visible on pop_data in the same
// cycle; if it is also popped that cycle it is never stored.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop all entries (a push in the same cycle is lost)
//   push_valid/push_data  write side; caller guarantees a free slot
//   pop_ready/pop_valid/pop_data  read side
//   count                 stored entries (bypassed beats not included)
module fetch_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned WIDTH  = 64,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             empty, bypass, do_store, do_read;

    always_comb begin
        empty     = (count_q == '0);
        bypass    = BYPASS && empty && push_valid;
        pop_valid = !empty || bypass;
        pop_data  = empty ? push_data : mem[rd_ptr_q];
        do_read   = pop_ready && !empty;
        // A bypassed beat consumed this cycle never occupies a slot.
        do_store  = push_valid && !(bypass && pop_ready);
        count     = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_store) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_read)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_store) - CW'(do_read);
        end
    end

    // Storage needs no reset; count_q qualifies every read.
    always_ff @(posedge clk) begin
        if (do_store && !flush) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: reads pc_current, issues imem requests, buffers
// responses with their PCs and hands them to decode in order. Returns pc_next
// (hold / +4 / redirect) to the PC register.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned-redirect trap + HALT).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   pc_current / pc_next               PC register loop (pc_next combinational)
//   redirect_valid / redirect_pc       flush and restart from execute
//   imem_req_valid/ready/addr          request channel (addr = pc_current)
//   imem_rsp_valid/data                in-order responses, never back-pressured
//   inst_valid/ready/data, inst_pc     decode interface
//   fetch_misalign                     misaligned-redirect trap pulse
module inst_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(cpu_pkg::RESET_PC),
    parameter int unsigned           DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pc_current,
    output logic [DATA_WIDTH-1:0] pc_next,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fetch_misalign
);

    import cpu_pkg::*;

    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam int unsigned EW        = 2 * DATA_WIDTH;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    fetch_state_t          state_q, state_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         tag_count, inst_count, in_flight;
    logic [CW:0]           credit_used;
    logic [DATA_WIDTH-1:0] redir_pc, tag_pc;
    logic [EW-1:0]         inst_entry;
    logic                  tag_valid, req_fire, rsp_accept, inst_fifo_valid;

`ifdef IF_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;

    always_comb begin
        redir_pc   = redirect_pc;
        misaligned = |redirect_pc[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= redirect_valid && misaligned;
    end

    assign fetch_misalign = misalign_q;
`else
    // Low address bits are ignored; instructions are always word aligned.
    assign redir_pc       = redirect_pc & ~DATA_WIDTH'(3);
    assign fetch_misalign = 1'b0;
`endif

    // Request / response control. The tag queue holds exactly the live
    // (non-dropped) requests, so tag_count + drop_q is the outstanding total.
    always_comb begin
        credit_used    = {1'b0, tag_count} + {1'b0, inst_count};
        imem_req_valid = (state_q == RUN) && (credit_used < DEPTH_LIM) &&
                         !redirect_valid && (drop_q == '0);
        imem_req_addr  = pc_current;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_accept     = imem_rsp_valid && (drop_q == '0);
        in_flight      = tag_count + drop_q + CW'(req_fire) - CW'(imem_rsp_valid);
    end

    always_comb begin
        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = in_flight;
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_comb begin
        if (redirect_valid) begin
            pc_next = redir_pc;
        end else if (state_q == BOOT) begin
            pc_next = RESET_PC;
        end else if (req_fire) begin
            pc_next = pc_current + DATA_WIDTH'(4);
        end else begin
            pc_next = pc_current;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
`ifdef IF_MISALIGN_TRAP_EN
            HALT:    state_d = HALT;
`else
            HALT:    state_d = RUN;
`endif
            default: state_d = BOOT;
        endcase
        if (redirect_valid) begin
`ifdef IF_MISALIGN_TRAP_EN
            state_d = misaligned ? HALT : RUN;
`else
            state_d = RUN;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .WIDTH  (DATA_WIDTH),
        .BYPASS (1'b0)
    ) u_tag_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push_valid (req_fire),
        .push_data  (pc_current),
        .pop_ready  (rsp_accept),
        .pop_valid  (tag_valid),
        .pop_data   (tag_pc),
        .count      (tag_count)
    );

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .WIDTH  (EW),
        .BYPASS (1'b1)
    ) u_inst_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push_valid (rsp_accept && tag_valid),
        .push_data  ({tag_pc, imem_rsp_data}),
        .pop_ready  (inst_ready && !redirect_valid),
        .pop_valid  (inst_fifo_valid),
        .pop_data   (inst_entry),
        .count      (inst_count)
    );

    // Nothing is offered to decode during a redirect: everything buffered is
    // on the wrong path and is flushed at the end of this cycle.
    always_comb begin
        inst_valid = inst_fifo_valid && !redirect_valid;
        inst_data  = inst_valid ? inst_entry[DATA_WIDTH-1:0] : DATA_WIDTH'(INST_NOP);
        inst_pc    = inst_entry[EW-1:DATA_WIDTH];
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: models the PC register and an in-order
// imem with configurable latency; a scoreboard queue tracks expected
// instructions from accepted requests and compares on each decode handshake.
module tb_inst_fetch;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BOOT_PC = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pc_reg = BOOT_PC;
    logic [DW-1:0] pc_next;
    logic          redirect_valid = 1'b0;
    logic [DW-1:0] redirect_pc = '0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [DW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [DW-1:0] imem_rsp_data = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_data;
    logic [DW-1:0] inst_pc;
    logic          fetch_misalign;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [DW-1:0] imem_addr_q[$];
    int            imem_due_q[$];
    logic [DW-1:0] exp_pc_q[$];
    logic [DW-1:0] exp_data_q[$];

    always #5 clk = ~clk;

    inst_fetch #(
        .DATA_WIDTH (DW),
        .RESET_PC   (BOOT_PC),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_current     (pc_reg),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_misalign (fetch_misalign)
    );

    function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // One clock: sample before the edge (scoreboard), advance models after it.
    task automatic tick();
        logic          fire;
        logic [DW-1:0] nxt, addr, e_pc, e_d;
        @(negedge clk);
        fire = imem_req_valid && imem_req_ready;
        nxt  = pc_next;
        addr = imem_req_addr;
        if (inst_valid && inst_ready) begin
            checks++;
            if (exp_pc_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h data=%h, expected no instruction",
                         inst_pc, inst_data);
            end else begin
                e_pc = exp_pc_q.pop_front();
                e_d  = exp_data_q.pop_front();
                if (inst_pc !== e_pc || inst_data !== e_d) begin
                    errors++;
                    $display("FAIL sb_inst: got pc=%h data=%h, expected pc=%h data=%h",
                             inst_pc, inst_data, e_pc, e_d);
                end
            end
        end
        if (redirect_valid) begin
            exp_pc_q.delete();
            exp_data_q.delete();
        end
        if (fire) begin
            exp_pc_q.push_back(addr);
            exp_data_q.push_back(mem_word(addr));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            pc_reg = BOOT_PC;
            imem_addr_q.delete();
            imem_due_q.delete();
            exp_pc_q.delete();
            exp_data_q.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            pc_reg = nxt;
            if (fire) begin
                imem_addr_q.push_back(addr);
                imem_due_q.push_back(cyc - 1 + lat);
            end
            if (imem_addr_q.size() > 0 && imem_due_q[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(imem_addr_q.pop_front());
                void'(imem_due_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b inst=%b mis=%b, expected 0 0 0",
                     imem_req_valid, inst_valid, fetch_misalign);
        end
        checks++;
        if (pc_next !== BOOT_PC) begin
            errors++;
            $display("FAIL reset_pc_next: got %h, expected %h", pc_next, BOOT_PC);
        end
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        rst_n          = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_no_req: got %b, expected 0", imem_req_valid);
        end
        tick();
    endtask

    task automatic test_stream();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000 || pc_next !== 32'h1004) begin
            errors++;
            $display("FAIL stream_first_req: got v=%b addr=%h next=%h, expected 1 1000 1004",
                     imem_req_valid, imem_req_addr, pc_next);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h1000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_inst_pc: got v=%b pc=%h, expected 1 %h",
                         inst_valid, inst_pc, 32'h1000 + 32'(4 * i));
            end
            checks++;
            if (pc_next !== 32'h1008 + 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_pc_next: got %h, expected %h",
                         pc_next, 32'h1008 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] hold_pc, hold_data;
        int            nreq;
        nreq = 0;
        inst_ready = 1'b0;
        #1;
        hold_pc   = inst_pc;
        hold_data = inst_data;
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_start: got %b, expected 1", inst_valid);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== hold_pc || inst_data !== hold_data) begin
                errors++;
                $display("FAIL bp_stable: got v=%b pc=%h data=%h, expected 1 %h %h",
                         inst_valid, inst_pc, inst_data, hold_pc, hold_data);
            end
            if (imem_req_valid && imem_req_ready) begin
                nreq++;
            end else begin
                checks++;
                if (pc_next !== pc_reg) begin
                    errors++;
                    $display("FAIL bp_pc_hold: got %h, expected %h", pc_next, pc_reg);
                end
            end
            tick();
        end
        checks++;
        if (nreq > 2) begin
            errors++;
            $display("FAIL bp_req_count: got %0d, expected <= 2", nreq);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_redirect();
        int n;
        lat = 3;
        n = 0;
        while (!(imem_addr_q.size() == 2 && !imem_rsp_valid) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL redir_setup: got %0d in flight, expected 2", imem_addr_q.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        #1;
        checks++;
        if (pc_next !== 32'h2000 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_cycle: got next=%h req=%b, expected 2000 0",
                     pc_next, imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: got inst_valid=%b, expected 0", inst_valid);
        end
        n = 0;
        while (!inst_valid && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h2000 || inst_data !== mem_word(32'h2000)) begin
            errors++;
            $display("FAIL redir_target: got v=%b pc=%h data=%h, expected 1 2000 %h",
                     inst_valid, inst_pc, inst_data, mem_word(32'h2000));
        end
        for (int i = 0; i < 6; i++) tick();
        lat = 1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_req_stall();
        logic [DW-1:0] held;
        int            n;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        held = pc_reg;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== held || pc_next !== held) begin
                errors++;
                $display("FAIL stall_hold: got v=%b addr=%h next=%h, expected 1 %h %h",
                         imem_req_valid, imem_req_addr, pc_next, held, held);
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000;
        #1;
        checks++;
        if (pc_next !== 32'h4000) begin
            errors++;
            $display("FAIL stall_redirect: got %h, expected 4000", pc_next);
        end
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4000) begin
            errors++;
            $display("FAIL stall_resume: got v=%b pc=%h, expected 1 4000", inst_valid, inst_pc);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_wrap();
        int n;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got v=%b addr=%h next=%h, expected 1 fffffffc 0",
                     imem_req_valid, imem_req_addr, pc_next);
        end
        tick();
        n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got v=%b addr=%h, expected 1 0",
                     imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_misalign();
        int n;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3002;
        #1;
`ifdef IF_MISALIGN_TRAP_EN
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (fetch_misalign !== 1'b1) begin
            errors++;
            $display("FAIL mis_pulse: got %b, expected 1", fetch_misalign);
        end
        tick();
        checks++;
        if (fetch_misalign !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse_end: got %b, expected 0", fetch_misalign);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL mis_halt_req: got %b, expected 0", imem_req_valid);
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        #1;
`else
        checks++;
        if (pc_next !== 32'h3000) begin
            errors++;
            $display("FAIL mis_align_pc: got %h, expected 3000", pc_next);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (fetch_misalign !== 1'b0) begin
            errors++;
            $display("FAIL mis_tied: got %b, expected 0", fetch_misalign);
        end
`endif
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h3000) begin
            errors++;
            $display("FAIL mis_resume: got v=%b pc=%h, expected 1 3000", inst_valid, inst_pc);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_req_stall();
        test_wrap();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
